// File: rtl/decode_pkg.sv
// Shared encodings and types for the decode front end: opcode/func constants,
// the op_class_t classification and the immediate format selector.
package decode_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_BACKDOOR = 7'b0001011;

    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [2:0] F3_BNE   = 3'b001;
    localparam logic [2:0] F3_W     = 3'b010;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_SRL   = 3'b101;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;
    localparam logic [2:0] F3_PRIV  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    localparam logic [11:0] IMM_ECALL = 12'h000;
    localparam logic [11:0] IMM_MRET  = 12'h302;

    typedef enum logic [3:0] {
        CLS_NONE     = 4'd0,
        CLS_LUI      = 4'd1,
        CLS_BRANCH   = 4'd2,
        CLS_LOAD     = 4'd3,
        CLS_STORE    = 4'd4,
        CLS_ALU_IMM  = 4'd5,
        CLS_ALU_REG  = 4'd6,
        CLS_ECALL    = 4'd7,
        CLS_MRET     = 4'd8,
        CLS_CSRRW    = 4'd9,
        CLS_BACKDOOR = 4'd10,
        CLS_ILLEGAL  = 4'd11
    } op_class_t;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_CSR   = 3'd2,
        IMM_SHAMT = 3'd3,
        IMM_S     = 3'd4,
        IMM_B     = 3'd5,
        IMM_U     = 3'd6
    } imm_fmt_t;

endpackage

// File: rtl/inst_classify.sv
// Combinational legality check: maps an instruction word to its class,
// immediate format and which register fields the class actually uses.
module inst_classify
    import decode_pkg::*;
#(
    parameter bit ENABLE_EXT      = 1'b0,
    parameter bit ENABLE_BACKDOOR = 1'b0
) (
    input  logic [31:0] inst,
    output op_class_t   cls,
    output imm_fmt_t    fmt,
    output logic        use_rd,
    output logic        use_rs1,
    output logic        use_rs2
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    always_comb begin
        cls     = CLS_ILLEGAL;
        fmt     = IMM_NONE;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_LUI: begin
                cls = CLS_LUI; fmt = IMM_U; use_rd = 1'b1;
            end
            OP_BRANCH: begin
                if (f3 == F3_BEQ || (ENABLE_EXT && f3 == F3_BNE)) begin
                    cls = CLS_BRANCH; fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
            end
            OP_LOAD: begin
                if (f3 == F3_W) begin
                    cls = CLS_LOAD; fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3 == F3_W) begin
                    cls = CLS_STORE; fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
            end
            OP_IMM: begin
                if (f3 == F3_ADD) begin
                    cls = CLS_ALU_IMM; fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                end else if (f7 == F7_ZERO && (f3 == F3_SRL || (ENABLE_EXT && f3 == F3_SLL))) begin
                    cls = CLS_ALU_IMM; fmt = IMM_SHAMT; use_rd = 1'b1; use_rs1 = 1'b1;
                end
            end
            OP_REG: begin
                if ((f3 == F3_ADD && f7 == F7_ZERO) ||
                    (ENABLE_EXT && f3 == F3_ADD && f7 == F7_SUB) ||
                    (ENABLE_EXT && f7 == F7_ZERO &&
                     (f3 == F3_XOR || f3 == F3_OR || f3 == F3_AND))) begin
                    cls = CLS_ALU_REG; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
            end
            OP_SYSTEM: begin
                // ECALL/MRET are only recognised with the exact canonical encoding
                if (f3 == F3_PRIV && inst[11:7] == 5'd0 && inst[19:15] == 5'd0) begin
                    if (inst[31:20] == IMM_ECALL)     cls = CLS_ECALL;
                    else if (inst[31:20] == IMM_MRET) cls = CLS_MRET;
                end else if (f3 == F3_CSRRW) begin
                    cls = CLS_CSRRW; fmt = IMM_CSR; use_rd = 1'b1; use_rs1 = 1'b1;
                end
            end
            OP_BACKDOOR: begin
                if (ENABLE_BACKDOOR) begin
                    cls = CLS_BACKDOOR; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready output register, immediate assembly and
// a saturating count of illegal instructions handed downstream.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter bit ENABLE_EXT      = 1'b0,
    parameter bit ENABLE_BACKDOOR = 1'b0,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_inst,
    output op_class_t        out_class,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] illegal_cnt
);

    op_class_t cls;
    imm_fmt_t  fmt;
    logic      use_rd, use_rs1, use_rs2;

    inst_classify #(
        .ENABLE_EXT      (ENABLE_EXT),
        .ENABLE_BACKDOOR (ENABLE_BACKDOOR)
    ) u_classify (
        .inst    (in_inst),
        .cls     (cls),
        .fmt     (fmt),
        .use_rd  (use_rd),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    // All formats are built as 32 bits with bit 31 as the sign, then widened
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:     imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            IMM_CSR:   imm32 = {20'd0, in_inst[31:20]};
            IMM_SHAMT: imm32 = {27'd0, in_inst[24:20]};
            IMM_S:     imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            IMM_B:     imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                in_inst[30:25], in_inst[11:8], 1'b0};
            IMM_U:     imm32 = {in_inst[31:12], 12'd0};
            default:   imm32 = '0;
        endcase
    end

    assign imm_ext = XLEN'($signed(imm32));

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    op_class_t        cls_q, cls_d;
    logic [4:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, fire_illegal;

    assign in_ready     = !valid_q || out_ready;
    assign load         = in_valid && in_ready && !flush;
    assign fire_illegal = valid_q && out_ready && (cls_q == CLS_ILLEGAL);

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cls_d   = cls_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            inst_d  = in_inst;
            cls_d   = cls;
            rd_d    = use_rd  ? in_inst[11:7]  : 5'd0;
            rs1_d   = use_rs1 ? in_inst[19:15] : 5'd0;
            rs2_d   = use_rs2 ? in_inst[24:20] : 5'd0;
            imm_d   = imm_ext;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // A handshake in the flush cycle still counts; the squashed entry never does
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear)
            cnt_d = '0;
        else if (fire_illegal && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            cls_q   <= CLS_NONE;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cls_q   <= cls_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_inst    = inst_q;
    assign out_class   = cls_q;
    assign out_rd      = rd_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_imm     = imm_q;
    assign out_illegal = (cls_q == CLS_ILLEGAL);
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a base-config instance and an extended-config
// instance (ext + backdoor, 2-bit counter) driven in lock-step.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        cnt_clear = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_pc, a_out_inst, a_out_imm;
    op_class_t   a_out_class;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_pc, b_out_inst, b_out_imm;
    op_class_t   b_out_class;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic [1:0]  b_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ENABLE_EXT(1'b0), .ENABLE_BACKDOOR(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_pc(a_out_pc), .out_inst(a_out_inst),
        .out_class(a_out_class), .out_rd(a_out_rd), .out_rs1(a_out_rs1),
        .out_rs2(a_out_rs2), .out_imm(a_out_imm), .out_illegal(a_out_illegal),
        .cnt_clear(cnt_clear), .illegal_cnt(a_cnt)
    );

    decode_stage #(.XLEN(32), .ENABLE_EXT(1'b1), .ENABLE_BACKDOOR(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_pc(b_out_pc), .out_inst(b_out_inst),
        .out_class(b_out_class), .out_rd(b_out_rd), .out_rs1(b_out_rs1),
        .out_rs2(b_out_rs2), .out_imm(b_out_imm), .out_illegal(b_out_illegal),
        .cnt_clear(cnt_clear), .illegal_cnt(b_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        op_class_t   cls_a;
        op_class_t   cls_b;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_a;
        int exp_b;
        logic [4:0]  e_rd, e_rs1, e_rs2;
        logic [31:0] e_imm;

        vecs[0]  = '{32'h00500093, CLS_ALU_IMM, CLS_ALU_IMM, 5'd1, 5'd0, 5'd0, 32'h00000005};
        vecs[1]  = '{32'h12345137, CLS_LUI,     CLS_LUI,     5'd2, 5'd0, 5'd0, 32'h12345000};
        vecs[2]  = '{32'hFE000EE3, CLS_BRANCH,  CLS_BRANCH,  5'd0, 5'd0, 5'd0, 32'hFFFFFFFC};
        vecs[3]  = '{32'h00512423, CLS_STORE,   CLS_STORE,   5'd0, 5'd2, 5'd5, 32'h00000008};
        vecs[4]  = '{32'hFFC12083, CLS_LOAD,    CLS_LOAD,    5'd1, 5'd2, 5'd0, 32'hFFFFFFFC};
        vecs[5]  = '{32'h0040D093, CLS_ALU_IMM, CLS_ALU_IMM, 5'd1, 5'd1, 5'd0, 32'h00000004};
        vecs[6]  = '{32'h4040D093, CLS_ILLEGAL, CLS_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h00000000};
        vecs[7]  = '{32'h00409093, CLS_ILLEGAL, CLS_ALU_IMM, 5'd1, 5'd1, 5'd0, 32'h00000004};
        vecs[8]  = '{32'hF14090F3, CLS_CSRRW,   CLS_CSRRW,   5'd1, 5'd1, 5'd0, 32'h00000F14};
        vecs[9]  = '{32'h002080B3, CLS_ALU_REG, CLS_ALU_REG, 5'd1, 5'd1, 5'd2, 32'h00000000};
        vecs[10] = '{32'h40208033, CLS_ILLEGAL, CLS_ALU_REG, 5'd0, 5'd1, 5'd2, 32'h00000000};
        vecs[11] = '{32'h0020C0B3, CLS_ILLEGAL, CLS_ALU_REG, 5'd1, 5'd1, 5'd2, 32'h00000000};
        vecs[12] = '{32'h00209463, CLS_ILLEGAL, CLS_BRANCH,  5'd0, 5'd1, 5'd2, 32'h00000008};
        vecs[13] = '{32'h00000073, CLS_ECALL,   CLS_ECALL,   5'd0, 5'd0, 5'd0, 32'h00000000};
        vecs[14] = '{32'h30200073, CLS_MRET,    CLS_MRET,    5'd0, 5'd0, 5'd0, 32'h00000000};
        vecs[15] = '{32'h000000F3, CLS_ILLEGAL, CLS_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h00000000};
        vecs[16] = '{32'h0020818B, CLS_ILLEGAL, CLS_BACKDOOR,5'd3, 5'd1, 5'd2, 32'h00000000};
        vecs[17] = '{32'h800000B7, CLS_LUI,     CLS_LUI,     5'd1, 5'd0, 5'd0, 32'h80000000};
        vecs[18] = '{32'h00000000, CLS_ILLEGAL, CLS_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h00000000};

        // reset state
        tick(); tick();
        chk("rst_valid", 64'(a_out_valid), 64'd0);
        chk("rst_class", 64'(a_out_class), 64'(CLS_NONE));
        chk("rst_imm", 64'(a_out_imm), 64'd0);
        chk("rst_cnt", 64'(a_cnt), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // streamed table, one instruction per cycle
        exp_a = 0;
        exp_b = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_inst = vecs[i].inst;
            in_pc = 32'h1000 + 32'(i * 4);
            tick();
            chk("a_valid", 64'(a_out_valid), 64'd1);
            chk("a_in_ready", 64'(a_in_ready), 64'd1);
            chk("a_pc", 64'(a_out_pc), 64'(32'h1000 + 32'(i * 4)));
            chk("a_inst", 64'(a_out_inst), 64'(vecs[i].inst));
            chk("a_class", 64'(a_out_class), 64'(vecs[i].cls_a));
            chk("a_illegal", 64'(a_out_illegal), 64'(vecs[i].cls_a == CLS_ILLEGAL));
            if (vecs[i].cls_a == CLS_ILLEGAL) begin
                e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0;
            end else begin
                e_rd = vecs[i].rd; e_rs1 = vecs[i].rs1; e_rs2 = vecs[i].rs2; e_imm = vecs[i].imm;
            end
            chk("a_rd", 64'(a_out_rd), 64'(e_rd));
            chk("a_rs1", 64'(a_out_rs1), 64'(e_rs1));
            chk("a_rs2", 64'(a_out_rs2), 64'(e_rs2));
            chk("a_imm", 64'(a_out_imm), 64'(e_imm));
            chk("a_cnt", 64'(a_cnt), 64'(exp_a));
            chk("b_class", 64'(b_out_class), 64'(vecs[i].cls_b));
            chk("b_rd", 64'(b_out_rd), 64'(vecs[i].rd));
            chk("b_rs1", 64'(b_out_rs1), 64'(vecs[i].rs1));
            chk("b_rs2", 64'(b_out_rs2), 64'(vecs[i].rs2));
            chk("b_imm", 64'(b_out_imm), 64'(vecs[i].imm));
            chk("b_cnt", 64'(b_cnt), 64'(exp_b));
            if (vecs[i].cls_a == CLS_ILLEGAL) exp_a++;
            if (vecs[i].cls_b == CLS_ILLEGAL && exp_b < 3) exp_b++;
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(a_out_valid), 64'd0);
        chk("table_cnt_a", 64'(a_cnt), 64'd8);
        chk("table_cnt_b", 64'(b_cnt), 64'd3);

        // clear wins over a simultaneous illegal handshake
        in_valid = 1'b1; in_inst = 32'h0;
        tick();
        in_valid = 1'b0; cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("clear_cnt_a", 64'(a_cnt), 64'd0);
        chk("clear_cnt_b", 64'(b_cnt), 64'd0);

        // three illegals, then two more to saturate the 2-bit counter
        in_valid = 1'b1; in_inst = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ill_flag", 64'(a_out_illegal), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("ill3_cnt_a", 64'(a_cnt), 64'd3);
        chk("ill3_cnt_b", 64'(b_cnt), 64'd3);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        tick();
        chk("ill5_cnt_a", 64'(a_cnt), 64'd5);
        chk("ill5_sat_b", 64'(b_cnt), 64'd3);

        // backpressure: X held for 4 cycles while Y waits
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h2000;
        tick();
        in_inst = 32'h12345137; in_pc = 32'h2004;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_in_ready", 64'(a_in_ready), 64'd0);
            chk("bp_valid", 64'(a_out_valid), 64'd1);
            chk("bp_inst", 64'(a_out_inst), 64'h00500093);
            chk("bp_pc", 64'(a_out_pc), 64'h2000);
            chk("bp_imm", 64'(a_out_imm), 64'd5);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(a_in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_y_valid", 64'(a_out_valid), 64'd1);
        chk("bp_y_inst", 64'(a_out_inst), 64'h12345137);
        chk("bp_y_pc", 64'(a_out_pc), 64'h2004);
        chk("bp_y_class", 64'(a_out_class), 64'(CLS_LUI));
        tick();
        chk("bp_y_once", 64'(a_out_valid), 64'd0);

        // flush a held illegal with a new offer: nothing captured, no count
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0;
        tick();
        in_inst = 32'h12345137; flush = 1'b1;
        tick();
        chk("fl_valid", 64'(a_out_valid), 64'd0);
        chk("fl_cnt", 64'(a_cnt), 64'd5);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_nocapture", 64'(a_out_valid), 64'd0);
        chk("fl_cnt2", 64'(a_cnt), 64'd5);

        // flush in the cycle an illegal completes its handshake: it counts
        in_valid = 1'b1; in_inst = 32'h0;
        tick();
        in_inst = 32'h12345137; flush = 1'b1;
        tick();
        chk("flhs_valid", 64'(a_out_valid), 64'd0);
        chk("flhs_cnt", 64'(a_cnt), 64'd6);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flhs_after", 64'(a_out_valid), 64'd0);

        // reset mid-stream
        in_valid = 1'b1; in_inst = 32'h12345137; in_pc = 32'h3000;
        tick();
        chk("mid_valid_pre", 64'(a_out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_class", 64'(a_out_class), 64'(CLS_NONE));
        chk("mid_rst_pc", 64'(a_out_pc), 64'd0);
        chk("mid_rst_inst", 64'(a_out_inst), 64'd0);
        chk("mid_rst_imm", 64'(a_out_imm), 64'd0);
        chk("mid_rst_rd", 64'(a_out_rd), 64'd0);
        chk("mid_rst_cnt", 64'(a_cnt), 64'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
